// File: rtl/ddr_cmd_sched.sv
// DDR4 host-side command scheduler: one request at a time, open-row tracking per
// bank, PRE/ACT/RD/WR sequencing with fixed spacing, and periodic refresh.
module ddr_cmd_sched #(
  parameter int ADDRWIDTH     = 17,
  parameter int BANKGROUPS    = 1,
  parameter int BGWIDTH       = $clog2(BANKGROUPS),
  parameter int BANKSPERGROUP = 8,
  parameter int BAWIDTH       = $clog2(BANKSPERGROUP),
  parameter int ROWWIDTH      = 9,
  parameter int COLWIDTH      = 9,
  parameter int TRCD          = 4,
  parameter int TRP           = 4,
  parameter int TCCD          = 4,
  parameter int TREFI         = 1024,
  parameter int TRFC          = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [BGWIDTH:0]     req_bg,
  input  logic [BAWIDTH:0]     req_ba,
  input  logic [ROWWIDTH-1:0]  req_row,
  input  logic [COLWIDTH-1:0]  req_col,
  output logic                 rsp_valid,
  output logic                 rsp_write,
  output logic                 cke,
  output logic                 cs_n,
  output logic                 act_n,
  output logic [ADDRWIDTH-1:0] addr,
  output logic [BAWIDTH:0]     ba,
  output logic [BGWIDTH:0]     bg
);

  localparam int NBANK = BANKGROUPS * BANKSPERGROUP;
  localparam int IDXW  = (NBANK > 1) ? $clog2(NBANK) : 1;
  localparam int WMAX1 = (TRCD > TRP) ? TRCD : TRP;
  localparam int WMAX2 = (TCCD > TRFC) ? TCCD : TRFC;
  localparam int WMAX  = (WMAX1 > WMAX2) ? WMAX1 : WMAX2;
  localparam int WAITW = $clog2(WMAX + 1);
  localparam int REFW  = $clog2(TREFI + 1);

  localparam logic [BAWIDTH:0] BA_MASK = (BAWIDTH+1)'((1 << BAWIDTH) - 1);
  localparam logic [BGWIDTH:0] BG_MASK = (BGWIDTH+1)'((1 << BGWIDTH) - 1);

  localparam logic [WAITW-1:0] W_ZERO = WAITW'(0);
  localparam logic [WAITW-1:0] W_ONE  = WAITW'(1);
  localparam logic [WAITW-1:0] W_RCD  = WAITW'(TRCD - 1);
  localparam logic [WAITW-1:0] W_RP   = WAITW'(TRP - 1);
  localparam logic [WAITW-1:0] W_CCD  = WAITW'(TCCD - 1);
  localparam logic [WAITW-1:0] W_RFC  = WAITW'(TRFC - 1);
  localparam logic [REFW-1:0]  REF_RELOAD = REFW'(TREFI - 1);
  localparam logic [REFW-1:0]  REF_ZERO   = REFW'(0);
  localparam logic [REFW-1:0]  REF_ONE    = REFW'(1);

  localparam logic [3:0] OP_ACT = 4'd1;
  localparam logic [3:0] OP_PRE = 4'd3;
  localparam logic [3:0] OP_RD  = 4'd4;
  localparam logic [3:0] OP_REF = 4'd5;
  localparam logic [3:0] OP_WR  = 4'd6;

  typedef enum logic [3:0] {
    S_IDLE, S_PRE, S_WAIT_RP, S_ACT, S_WAIT_RCD, S_COL,
    S_WAIT_CCD, S_PREA, S_WAIT_RPA, S_REF, S_WAIT_RFC
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [WAITW-1:0]      r_wait, w_wait_nxt;
  logic [REFW-1:0]       r_ref_cnt, w_ref_cnt_nxt;
  logic                  r_ref_pending, w_ref_pending_nxt, w_ref_expire;
  logic [NBANK-1:0]      r_open;
  logic [ROWWIDTH-1:0]   r_open_row [NBANK];
  logic                  r_req_write;
  logic [BGWIDTH:0]      r_req_bg;
  logic [BAWIDTH:0]      r_req_ba;
  logic [ROWWIDTH-1:0]   r_req_row;
  logic [COLWIDTH-1:0]   r_req_col;
  logic [IDXW-1:0]       r_req_idx, w_idx;
  logic                  w_cmd, w_bank_cmd, w_accept, w_rsp, w_ready_nxt;
  logic [3:0]            w_op;
  logic [12:0]           w_payload;
  logic                  r_cke, r_cs_n, r_rsp_valid, r_rsp_write, r_ready;
  logic [ADDRWIDTH-1:0]  r_addr;
  logic [BAWIDTH:0]      r_ba;
  logic [BGWIDTH:0]      r_bg;

  assign w_idx = IDXW'(32'(req_bg & BG_MASK) * BANKSPERGROUP + 32'(req_ba & BA_MASK));

  // Refresh interval counter; expiry is sticky until REF is actually issued
  always_comb begin
    w_ref_cnt_nxt = r_ref_cnt;
    w_ref_expire  = 1'b0;
    if (r_cke) begin
      if (r_ref_cnt == REF_ZERO) begin
        w_ref_cnt_nxt = REF_RELOAD;
        w_ref_expire  = 1'b1;
      end else begin
        w_ref_cnt_nxt = r_ref_cnt - REF_ONE;
      end
    end else begin
      w_ref_cnt_nxt = r_ref_cnt;
    end
    w_ref_pending_nxt = w_ref_expire | (r_ref_pending & (r_state != S_REF));
  end

  // Next-state and command decode; command states drive the bus on their exit edge
  always_comb begin
    w_state_nxt = r_state;
    w_wait_nxt  = r_wait;
    w_cmd       = 1'b0;
    w_bank_cmd  = 1'b0;
    w_op        = 4'd0;
    w_payload   = 13'd0;
    w_accept    = 1'b0;
    w_rsp       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_ref_pending) begin
          w_state_nxt = (|r_open) ? S_PREA : S_REF;
        end else if (req_valid && r_ready) begin
          w_accept = 1'b1;
          if (!r_open[w_idx]) begin
            w_state_nxt = S_ACT;
          end else if (r_open_row[w_idx] == req_row) begin
            w_state_nxt = S_COL;
          end else begin
            w_state_nxt = S_PRE;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_PRE: begin
        w_cmd = 1'b1; w_bank_cmd = 1'b1; w_op = OP_PRE;
        w_wait_nxt  = W_RP;
        w_state_nxt = (TRP > 1) ? S_WAIT_RP : S_ACT;
      end
      S_WAIT_RP: begin
        if (r_wait == W_ONE) w_state_nxt = S_ACT;
        else                 w_wait_nxt  = r_wait - W_ONE;
      end
      S_ACT: begin
        w_cmd = 1'b1; w_bank_cmd = 1'b1; w_op = OP_ACT;
        w_payload   = 13'(r_req_row);
        w_wait_nxt  = W_RCD;
        w_state_nxt = (TRCD > 1) ? S_WAIT_RCD : S_COL;
      end
      S_WAIT_RCD: begin
        if (r_wait == W_ONE) w_state_nxt = S_COL;
        else                 w_wait_nxt  = r_wait - W_ONE;
      end
      S_COL: begin
        w_cmd = 1'b1; w_bank_cmd = 1'b1; w_rsp = 1'b1;
        w_op        = r_req_write ? OP_WR : OP_RD;
        w_payload   = 13'(r_req_col);
        w_wait_nxt  = W_CCD;
        w_state_nxt = S_WAIT_CCD;
      end
      S_WAIT_CCD: begin
        if (r_wait == W_ZERO) w_state_nxt = S_IDLE;
        else                  w_wait_nxt  = r_wait - W_ONE;
      end
      S_PREA: begin
        w_cmd = 1'b1; w_op = OP_PRE;
        w_payload   = 13'h0400;
        w_wait_nxt  = W_RP;
        w_state_nxt = (TRP > 1) ? S_WAIT_RPA : S_REF;
      end
      S_WAIT_RPA: begin
        if (r_wait == W_ONE) w_state_nxt = S_REF;
        else                 w_wait_nxt  = r_wait - W_ONE;
      end
      S_REF: begin
        w_cmd = 1'b1; w_op = OP_REF;
        w_wait_nxt  = W_RFC;
        w_state_nxt = (TRFC > 1) ? S_WAIT_RFC : S_IDLE;
      end
      S_WAIT_RFC: begin
        if (r_wait == W_ONE) w_state_nxt = S_IDLE;
        else                 w_wait_nxt  = r_wait - W_ONE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    w_ready_nxt = (w_state_nxt == S_IDLE) && r_cke && !w_ref_pending_nxt;
  end

  // FSM, wait and refresh registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_wait        <= W_ZERO;
      r_ref_cnt     <= REF_RELOAD;
      r_ref_pending <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_wait        <= w_wait_nxt;
      r_ref_cnt     <= w_ref_cnt_nxt;
      r_ref_pending <= w_ref_pending_nxt;
    end
  end

  // Request latch, captured on the accepting edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_req_write <= 1'b0;
      r_req_bg    <= '0;
      r_req_ba    <= '0;
      r_req_row   <= '0;
      r_req_col   <= '0;
      r_req_idx   <= '0;
    end else if (w_accept) begin
      r_req_write <= req_write;
      r_req_bg    <= req_bg & BG_MASK;
      r_req_ba    <= req_ba & BA_MASK;
      r_req_row   <= req_row;
      r_req_col   <= req_col;
      r_req_idx   <= w_idx;
    end
  end

  // Open-row table
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_open <= {NBANK{1'b0}};
      for (int i = 0; i < NBANK; i++) r_open_row[i] <= '0;
    end else begin
      case (r_state)
        S_ACT: begin
          r_open[r_req_idx]     <= 1'b1;
          r_open_row[r_req_idx] <= r_req_row;
        end
        S_PRE:         r_open[r_req_idx] <= 1'b0;
        S_PREA, S_REF: r_open <= {NBANK{1'b0}};
        default: ;
      endcase
    end
  end

  // Registered pin-level command bus and handshake outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cke       <= 1'b0;
      r_cs_n      <= 1'b1;
      r_addr      <= '0;
      r_ba        <= '0;
      r_bg        <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_write <= 1'b0;
      r_ready     <= 1'b0;
    end else begin
      r_cke       <= 1'b1;
      r_cs_n      <= ~w_cmd;
      r_addr      <= w_cmd ? ADDRWIDTH'({w_op, w_payload}) : '0;
      r_ba        <= w_bank_cmd ? r_req_ba : '0;
      r_bg        <= w_bank_cmd ? r_req_bg : '0;
      r_rsp_valid <= w_rsp;
      r_rsp_write <= w_rsp & r_req_write;
      r_ready     <= w_ready_nxt;
    end
  end

  assign cke       = r_cke;
  assign cs_n      = r_cs_n;
  assign act_n     = 1'b1;
  assign addr      = r_addr;
  assign ba        = r_ba;
  assign bg        = r_bg;
  assign rsp_valid = r_rsp_valid;
  assign rsp_write = r_rsp_write;
  assign req_ready = r_ready;

endmodule
